// File: rtl/encoder8_3_pipe.sv
// Two-stage one-hot to binary encoder with a shared stall, an error flag for
// non-one-hot inputs and a saturating error counter.
module encoder8_3_pipe #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [7:0]           i_data_in,
    input  logic                 i_data_in_en,
    output logic                 o_ready,
    input  logic                 i_out_ready,
    input  logic                 i_err_clr,
    output logic [2:0]           encoder_out,
    output logic                 encoder_valid,
    output logic                 encoder_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int STAGES = 2;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES:1] vld_pipe;
    logic [7:0]      s1_data;
    logic            advance;
    logic [2:0]      enc_idx;
    logic            enc_err;
    logic            err_inc;

    // Both stages move together; a full output register only blocks when
    // the consumer is not taking it.
    assign advance       = !encoder_valid || i_out_ready;
    assign o_ready       = advance;
    assign encoder_valid = vld_pipe[STAGES];

    // Ascending scan so the last hit wins: the highest set bit has priority.
    always_comb begin
        enc_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s1_data[i]) enc_idx = 3'(i);
        end
        enc_err = (s1_data == 8'd0) || ((s1_data & (s1_data - 8'd1)) != 8'd0);
    end

    assign err_inc = advance && vld_pipe[1] && enc_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe    <= '0;
            s1_data     <= 8'd0;
            encoder_out <= 3'd0;
            encoder_err <= 1'b0;
        end else if (advance) begin
            vld_pipe    <= {vld_pipe[STAGES-1:1], i_data_in_en};
            s1_data     <= i_data_in;
            encoder_out <= enc_idx;
            encoder_err <= enc_err;
        end
    end

    // Clear dominates a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_count <= '0;
        end else if (i_err_clr) begin
            err_count <= '0;
        end else if (err_inc && (err_count != CNT_MAX)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_encoder8_3_pipe.sv
// Scoreboard bench for encoder8_3_pipe: a default-width instance plus a
// 2-bit counter instance share stimulus to exercise counter saturation.
module tb_encoder8_3_pipe;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_data_in;
    logic       i_data_in_en;
    logic       i_out_ready;
    logic       i_err_clr;

    logic       o_ready, encoder_valid, encoder_err;
    logic [2:0] encoder_out;
    logic [7:0] err_count;

    logic       o_ready2, encoder_valid2, encoder_err2;
    logic [2:0] encoder_out2;
    logic [1:0] err_count2;

    encoder8_3_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_in(i_data_in),
        .i_data_in_en(i_data_in_en), .o_ready(o_ready), .i_out_ready(i_out_ready),
        .i_err_clr(i_err_clr), .encoder_out(encoder_out), .encoder_valid(encoder_valid),
        .encoder_err(encoder_err), .err_count(err_count)
    );

    encoder8_3_pipe #(.ERR_CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_in(i_data_in),
        .i_data_in_en(i_data_in_en), .o_ready(o_ready2), .i_out_ready(i_out_ready),
        .i_err_clr(i_err_clr), .encoder_out(encoder_out2), .encoder_valid(encoder_valid2),
        .encoder_err(encoder_err2), .err_count(err_count2)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0] out;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         chk_lat = 1'b0;
    int         m8 = 0;
    int         m2 = 0;
    bit         stall_prev = 1'b0;
    logic [2:0] prev_out = 3'd0;
    logic       prev_err = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input int c);
        exp_t e;
        e.out = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (d[i]) begin
                e.out = 3'(i);
                break;
            end
        end
        e.err = ($countones(d) != 1);
        e.cyc = c;
        return e;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    // Monitor: pops results, checks stall stability, pushes accepted inputs.
    always @(negedge i_clk) begin : mon
        exp_t e;
        if (!i_rst_n) begin
            q.delete();
            m8 = 0;
            m2 = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", int'(encoder_valid), 1);
                chk("hold_out", int'(encoder_out), int'(prev_out));
                chk("hold_err", int'(encoder_err), int'(prev_err));
            end
            if (encoder_valid && i_out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("enc_out", int'(encoder_out), int'(e.out));
                    chk("enc_err", int'(encoder_err), int'(e.err));
                    if (chk_lat) chk("latency", cyc - e.cyc, 2);
                end
            end
            if (i_err_clr) begin
                m8 = 0;
                m2 = 0;
            end
            if (i_data_in_en && o_ready) begin
                e = model(i_data_in, cyc);
                q.push_back(e);
                if (e.err) begin
                    if (m8 < 255) m8++;
                    if (m2 < 3) m2++;
                end
            end
            stall_prev = encoder_valid && !i_out_ready;
            prev_out   = encoder_out;
            prev_err   = encoder_err;
        end
    end

    task automatic step(input bit en, input logic [7:0] d);
        i_data_in_en = en;
        i_data_in    = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        i_out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("drain_empty", q.size(), 0);
        chk("cnt8_model", int'(err_count), m8);
        chk("cnt2_model", int'(err_count2), m2);
    endtask

    initial begin
        logic [7:0] seq[5];
        int         sat_exp[5];
        seq     = '{8'h02, 8'h80, 8'h20, 8'h04, 8'h01};
        sat_exp = '{1, 2, 3, 3, 3};

        i_rst_n      = 1'b1;
        i_data_in    = 8'h10;
        i_data_in_en = 1'b1;
        i_out_ready  = 1'b1;
        i_err_clr    = 1'b0;
        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_valid", int'(encoder_valid), 0);
        chk("rst_out", int'(encoder_out), 0);
        chk("rst_err", int'(encoder_err), 0);
        chk("rst_cnt8", int'(err_count), 0);
        chk("rst_cnt2", int'(err_count2), 0);
        i_rst_n = 1'b1;
        step(1'b0, 8'h00);

        // Back-to-back one-hot stream at full throughput.
        chk_lat = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, seq[i]);
        drain();
        chk("cnt_clean", int'(err_count), 0);

        // Zero and multi-hot inputs.
        step(1'b1, 8'h00);
        step(1'b1, 8'h81);
        drain();
        chk("cnt_two_err", int'(err_count), 2);

        // Output stall with both stages full.
        chk_lat = 1'b0;
        i_out_ready = 1'b0;
        step(1'b1, 8'h40);
        step(1'b1, 8'h20);
        i_data_in    = 8'h10;
        i_data_in_en = 1'b1;
        repeat (5) begin
            chk("stall_ready", int'(o_ready), 0);
            chk("stall_out", int'(encoder_out), 6);
            @(posedge i_clk);
            #1;
        end
        i_out_ready = 1'b1;
        step(1'b1, 8'h10);
        drain();
        chk_lat = 1'b1;

        // Clear, then saturate the 2-bit counter.
        i_err_clr = 1'b1;
        step(1'b0, 8'h00);
        i_err_clr = 1'b0;
        step(1'b0, 8'h00);
        chk("clr_cnt8", int'(err_count), 0);
        chk("clr_cnt2", int'(err_count2), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h00);
            drain();
            chk("sat_cnt2", int'(err_count2), sat_exp[i]);
            chk("inc_cnt8", int'(err_count), i + 1);
        end
        // Clear lands on the same edge as the stage-1 to stage-2 increment.
        step(1'b1, 8'hff);
        i_err_clr = 1'b1;
        step(1'b0, 8'h00);
        i_err_clr = 1'b0;
        drain();
        chk("clr_inc_cnt2", int'(err_count2), 0);
        chk("clr_inc_cnt8", int'(err_count), 0);

        // Reset with both stages full and a nonzero counter.
        i_out_ready = 1'b0;
        step(1'b1, 8'h03);
        step(1'b1, 8'h04);
        i_data_in_en = 1'b1;
        i_data_in    = 8'h80;
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(encoder_valid), 0);
        chk("mid_rst_out", int'(encoder_out), 0);
        chk("mid_rst_err", int'(encoder_err), 0);
        chk("mid_rst_ready", int'(o_ready), 1);
        chk("mid_rst_cnt8", int'(err_count), 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n     = 1'b1;
        i_out_ready = 1'b1;
        step(1'b1, 8'h08);
        step(1'b0, 8'h00);
        chk("post_rst_valid", int'(encoder_valid), 1);
        chk("post_rst_out", int'(encoder_out), 3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
